// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath
// Sequences fetch/decode/execute/memory/writeback with a mem_ready stall and bus-error timeout.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       halted,
  output logic       bus_err,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    FETCH   = 5'd0,
    DECODE  = 5'd1,
    MEMADR  = 5'd2,
    MEMRD   = 5'd3,
    MEMWB   = 5'd4,
    MEMWR   = 5'd5,
    REX     = 5'd6,
    RWB     = 5'd7,
    BEQ     = 5'd8,
    JUMP    = 5'd9,
    JAL     = 5'd10,
    JR      = 5'd11,
    ADDI_EX = 5'd12,
    IMM_WB  = 5'd13,
    ANDI_EX = 5'd14,
    HALT    = 5'd31
  } state_t;

  state_t             cur, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               berr_q;
  logic               waiting;
  logic               timeout;

  // Only the memory-access states can stall; the counter is idle elsewhere.
  assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign timeout = waiting && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));
  assign cnt_nxt = (waiting && !mem_ready) ? cnt + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur    <= FETCH;
      cnt    <= '0;
      berr_q <= 1'b0;
    end else begin
      cur    <= nxt;
      cnt    <= cnt_nxt;
      berr_q <= berr_q | timeout;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:   if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (Op)
          6'd0:         nxt = (Funct == 6'd8) ? JR : REX;
          6'd35, 6'd43: nxt = MEMADR;
          6'd4:         nxt = BEQ;
          6'd2:         nxt = JUMP;
          6'd3:         nxt = JAL;
          6'd8:         nxt = ADDI_EX;
          6'd12:        nxt = ANDI_EX;
          default:      nxt = HALT;
        endcase
      end
      MEMADR:  nxt = (Op == 6'd35) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) nxt = MEMWB;
      MEMWB:   nxt = FETCH;
      MEMWR:   if (mem_ready) nxt = FETCH;
      REX:     nxt = RWB;
      RWB:     nxt = FETCH;
      BEQ:     nxt = FETCH;
      JUMP:    nxt = FETCH;
      JAL:     nxt = FETCH;
      JR:      nxt = FETCH;
      ADDI_EX: nxt = IMM_WB;
      ANDI_EX: nxt = IMM_WB;
      IMM_WB:  nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
    if (timeout) nxt = HALT;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ZeroExt     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    halted      = 1'b0;
    case (cur)
      FETCH: begin
        // PC+4 and IR load only commit once memory has returned the word.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ANDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ZeroExt = 1'b1;
        ALUOp   = 2'b11;
      end
      IMM_WB:  RegWrite = 1'b1;
      HALT:    halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

  assign bus_err = berr_q;
  assign state   = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
// Per-cycle comparison against an instruction-path model plus directed literal checks.
module tb_multicycle_control;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, PCSource, ALUOp, ALUSrcB, RegDst;
  logic       ALUSrcA, ZeroExt, RegWrite, halted, bus_err;
  logic [4:0] state;

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
    .RegWrite(RegWrite), .RegDst(RegDst), .halted(halted), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int trace[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: current state code plus the remaining state path of the instruction.
  int m_cur = 0;
  int m_rest[$];
  int m_wait = 0;
  bit m_berr = 0;

  function automatic logic [20:0] exp_ctrl(input int s, input logic mr, input bit be);
    logic       pcw, pcwc, iord, mrd, mwr, irw, alua, zext, rw, hlt;
    logic [1:0] m2r, pcs, aop, alub, rdst;
    pcw  = (s == 0 && mr) || s == 9 || s == 10 || s == 11;
    pcwc = (s == 8);
    iord = (s == 3 || s == 5);
    mrd  = (s == 0 || s == 3);
    mwr  = (s == 5);
    irw  = (s == 0 && mr);
    m2r  = (s == 4) ? 2'd1 : (s == 10) ? 2'd2 : 2'd0;
    pcs  = (s == 8) ? 2'd1 : (s == 9 || s == 10) ? 2'd2 : (s == 11) ? 2'd3 : 2'd0;
    aop  = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : (s == 14) ? 2'd3 : 2'd0;
    alua = (s == 2 || s == 6 || s == 8 || s == 12 || s == 14);
    alub = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s == 2 || s == 12 || s == 14) ? 2'd2 : 2'd0;
    zext = (s == 14);
    rw   = (s == 4 || s == 7 || s == 10 || s == 13);
    rdst = (s == 7) ? 2'd1 : (s == 10) ? 2'd2 : 2'd0;
    hlt  = (s == 31);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aop, alua, alub, zext, rw, rdst, hlt, be};
  endfunction

  task automatic advance();
    m_cur = (m_rest.size() != 0) ? m_rest.pop_front() : 0;
  endtask

  task automatic stall_tick();
    m_wait++;
    if (m_wait >= TIMEOUT) begin
      m_cur  = 31;
      m_berr = 1;
    end
  endtask

  task automatic model_step();
    if (m_cur == 31) return;
    case (m_cur)
      0: if (mem_ready) begin m_wait = 0; m_cur = 1; end else stall_tick();
      3, 5: if (mem_ready) begin m_wait = 0; advance(); end else stall_tick();
      1: begin
        m_rest.delete();
        case (Op)
          6'd0:  if (Funct == 6'd8) m_rest.push_back(11);
                 else begin m_rest.push_back(6); m_rest.push_back(7); end
          6'd35: begin m_rest.push_back(2); m_rest.push_back(3); m_rest.push_back(4); end
          6'd43: begin m_rest.push_back(2); m_rest.push_back(5); end
          6'd4:  m_rest.push_back(8);
          6'd2:  m_rest.push_back(9);
          6'd3:  m_rest.push_back(10);
          6'd8:  begin m_rest.push_back(12); m_rest.push_back(13); end
          6'd12: begin m_rest.push_back(14); m_rest.push_back(13); end
          default: m_rest.push_back(31);
        endcase
        advance();
      end
      default: advance();
    endcase
  endtask

  logic [20:0] act_ctrl;
  assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     PCSource, ALUOp, ALUSrcA, ALUSrcB, ZeroExt, RegWrite, RegDst,
                     halted, bus_err};

  always @(negedge clk) begin
    if (reset) begin
      m_cur = 0;
      m_rest.delete();
      m_wait = 0;
      m_berr = 0;
    end
    chk("model_state", 32'(state), 32'(m_cur));
    chk("model_ctrl", 32'(act_ctrl), 32'(exp_ctrl(m_cur, mem_ready, m_berr)));
    if (!reset) model_step();
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic mr);
    Op = op;
    Funct = fn;
    mem_ready = mr;
    trace.push_back(int'(state));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_berr", 32'(bus_err), 32'd0);
    drive(6'd0, 6'd32, 1'b1);
    drive(6'd0, 6'd32, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_r[5];
    int n3;
    exp_r = '{0, 1, 6, 7, 0};
    @(posedge clk);
    #1;
    do_reset();

    // R-type add: 0,1,6,7,0
    trace.delete();
    drive(6'd0, 6'd32, 1'b1);
    drive(6'd0, 6'd32, 1'b1);
    chk("rex_aluop", 32'(ALUOp), 32'd2);
    drive(6'd0, 6'd32, 1'b1);
    chk("rwb_regwrite_regdst", 32'({RegWrite, RegDst}), 32'b101);
    drive(6'd0, 6'd32, 1'b1);
    trace.push_back(int'(state));
    for (int i = 0; i < 5; i++) chk($sformatf("r_trace%0d", i), 32'(trace[i]), 32'(exp_r[i]));

    // lw with three wait cycles in MEMRD: 8 cycles total
    trace.delete();
    drive(6'd35, 6'd0, 1'b1);
    drive(6'd35, 6'd0, 1'b1);
    drive(6'd35, 6'd0, 1'b1);
    chk("memrd_read_iord", 32'({MemRead, IorD}), 32'b11);
    drive(6'd35, 6'd0, 1'b0);
    drive(6'd35, 6'd0, 1'b0);
    drive(6'd35, 6'd0, 1'b0);
    drive(6'd35, 6'd0, 1'b1);
    chk("memwb_memtoreg", 32'(MemtoReg), 32'd1);
    drive(6'd35, 6'd0, 1'b1);
    n3 = 0;
    foreach (trace[i]) if (trace[i] == 3) n3++;
    chk("lw_cycles", 32'(trace.size()), 32'd8);
    chk("lw_memrd_cycles", 32'(n3), 32'd4);
    chk("lw_back_fetch", 32'(state), 32'd0);

    // beq
    drive(6'd4, 6'd0, 1'b1);
    drive(6'd4, 6'd0, 1'b1);
    chk("beq_ctrl", 32'({ALUOp, PCWriteCond, PCSource, PCWrite}), 32'b011010);
    drive(6'd4, 6'd0, 1'b1);

    // andi
    drive(6'd12, 6'd0, 1'b1);
    drive(6'd12, 6'd0, 1'b1);
    chk("andi_ctrl", 32'({state, ALUOp, ZeroExt}), {24'd0, 5'd14, 2'b11, 1'b1});
    drive(6'd12, 6'd0, 1'b1);
    drive(6'd12, 6'd0, 1'b1);

    // jr
    drive(6'd0, 6'd8, 1'b1);
    drive(6'd0, 6'd8, 1'b1);
    chk("jr_ctrl", 32'({state, PCWrite, PCSource, RegWrite}), {23'd0, 5'd11, 4'b1110});
    drive(6'd0, 6'd8, 1'b1);

    // jal
    drive(6'd3, 6'd0, 1'b1);
    drive(6'd3, 6'd0, 1'b1);
    chk("jal_ctrl", 32'({state, RegDst, MemtoReg, RegWrite}), {22'd0, 5'd10, 5'b10101});
    drive(6'd3, 6'd0, 1'b1);

    // sw with one wait, addi, j
    drive(6'd43, 6'd0, 1'b1);
    drive(6'd43, 6'd0, 1'b1);
    drive(6'd43, 6'd0, 1'b1);
    drive(6'd43, 6'd0, 1'b0);
    drive(6'd43, 6'd0, 1'b1);
    chk("sw_back_fetch", 32'(state), 32'd0);
    for (int i = 0; i < 4; i++) drive(6'd8, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) drive(6'd2, 6'd0, 1'b1);
    chk("addi_j_back_fetch", 32'(state), 32'd0);

    // reset mid-instruction (in MEMADR)
    drive(6'd35, 6'd0, 1'b1);
    drive(6'd35, 6'd0, 1'b1);
    chk("pre_reset_memadr", 32'(state), 32'd2);
    do_reset();

    // illegal opcode halts
    drive(6'd63, 6'd0, 1'b1);
    drive(6'd63, 6'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_flags", 32'({state, halted, bus_err}), {25'd0, 5'd31, 2'b10});
      chk("halt_enables", 32'({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
      drive(6'd63, 6'd0, 1'b1);
    end
    do_reset();

    // fetch timeout: 16 cycles without mem_ready
    for (int i = 0; i < 15; i++) begin
      drive(6'd0, 6'd32, 1'b0);
      chk("timeout_irwrite", 32'(IRWrite), 32'd0);
    end
    chk("timeout_still_fetch", 32'(state), 32'd0);
    drive(6'd0, 6'd32, 1'b0);
    chk("timeout_halt", 32'({state, bus_err, IRWrite}), {25'd0, 5'd31, 2'b10});
    drive(6'd0, 6'd32, 1'b1);
    drive(6'd0, 6'd32, 1'b1);
    chk("timeout_sticky", 32'({state, bus_err}), {26'd0, 5'd31, 1'b1});
    do_reset();

    // mem_ready arrives on the last allowed cycle
    for (int i = 0; i < 15; i++) drive(6'd0, 6'd32, 1'b0);
    drive(6'd0, 6'd32, 1'b1);
    chk("late_ready_decode", 32'({state, bus_err}), {26'd0, 5'd1, 1'b0});
    drive(6'd0, 6'd32, 1'b1);
    drive(6'd0, 6'd32, 1'b1);
    drive(6'd0, 6'd32, 1'b1);
    chk("late_ready_done", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences one instruction over 3–5 cycles: fetch, decode, execute, memory, writeback. Drives the datapath muxes, register/memory enables and the 2-bit ALUOp consumed by the ALU control decoder. Stalls on a memory ready handshake and halts on an illegal opcode or a memory timeout.

Parameters:
TIMEOUT, 16, max cycles a memory access may wait for mem_ready before bus error (≥2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
mem_ready  in  1  memory completes current MemRead/MemWrite this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
IorD  out  1  0=PC addresses memory, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR (and MDR)
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
ALUOp  out  2  00 ADD, 01 SUB, 10 RFORMAT, 11 AND
ALUSrcA  out  1  0=PC, 1=reg A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 ext imm, 11 sext imm<<2
ZeroExt  out  1  immediate zero-extended instead of sign-extended
RegWrite  out  1  register file write
RegDst  out  2  00 rt, 01 rd, 10 $31
halted  out  1  FSM in HALT
bus_err  out  1  halt caused by memory timeout
state  out  5  current state code (debug)

Behaviour:
- Reset (async): state=FETCH, wait counter=0, bus_err=0. All outputs are the combinational decode of FETCH with mem_ready gating.
- Outputs are decoded from state. IRWrite and PCWrite in FETCH are additionally ANDed with mem_ready (Mealy). All unlisted outputs are 0.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, JUMP=9, JAL=10, JR=11, ADDI_EX=12, IMM_WB=13, ANDI_EX=14, HALT=31.
- FETCH:
  - Outputs: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite&mem_ready, PCWrite&mem_ready.
  - Transition: to DECODE when mem_ready, else stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut).
  - Next state by Op:
    - Op=0, Funct=8 → JR
    - Op=0, other Funct → REX
    - Op=35 or 43 → MEMADR
    - Op=4 → BEQ
    - Op=2 → JUMP
    - Op=3 → JAL
    - Op=8 → ADDI_EX
    - Op=12 → ANDI_EX
    - any other Op → HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Op=35 → MEMRD, else → MEMWR.
- MEMRD: MemRead, IorD=1. On mem_ready → MEMWB, else stay.
- MEMWB: RegWrite, RegDst=00, MemtoReg=01 → FETCH.
- MEMWR: MemWrite, IorD=1. On mem_ready → FETCH, else stay.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RWB.
- RWB: RegWrite, RegDst=01, MemtoReg=00 → FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 → FETCH.
- JUMP: PCWrite, PCSource=10 → FETCH.
- JAL: PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=10 (PC already holds PC+4) → FETCH.
- JR: PCWrite, PCSource=11 → FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → IMM_WB.
- ANDI_EX: ALUSrcA=1, ALUSrcB=10, ZeroExt=1, ALUOp=11 → IMM_WB.
- IMM_WB: RegWrite, RegDst=00, MemtoReg=00 → FETCH.
- HALT: all controls 0, halted=1. Exit only by reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0: next state is HALT, bus_err set to 1 (sticky until reset).
  - mem_ready=1 in that same cycle wins: normal transition, no error.
- Instruction latency with mem_ready=1 every cycle:
  - 3 cycles: JUMP, JAL, JR, BEQ
  - 4 cycles: R-type, ADDI, ANDI, sw
  - 5 cycles: lw
  - Each wait cycle adds 1.
- Reset asserted mid-instruction: state returns to FETCH immediately. No write enable may be asserted while reset is high, except FETCH's gated IRWrite/PCWrite; the datapath holds its own reset.

Test Plan:
- Reset, mem_ready=1, Op=0, Funct=32 → states 0,1,6,7,0. In state 6 ALUOp=10; in state 7 RegWrite=1, RegDst=01.
- Op=35, mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles with MemRead=1, IorD=1, then MEMWB with MemtoReg=01. Total 8 cycles.
- Op=4 → BEQ cycle: ALUOp=01, PCWriteCond=1, PCSource=01, PCWrite=0. Op=12 → ANDI_EX: ALUOp=11, ZeroExt=1.
- Op=0, Funct=8 → JR: PCWrite=1, PCSource=11, RegWrite=0. Op=3 → JAL: RegDst=10, MemtoReg=10, RegWrite=1.
- Op=63 → HALT after DECODE: halted=1, bus_err=0, all enables 0 for ≥10 cycles. Reset → FETCH.
- mem_ready held 0 in FETCH with TIMEOUT=16 → HALT entered after cycle 16, bus_err=1, IRWrite never 1. Repeat with mem_ready=1 on cycle 16 → DECODE, no error.
